// File: rtl/row_sync_pkg.sv
// rtl/row_sync_pkg.sv - shared state/op-kind types for the row sync engine
package row_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_CAP,
        WB_SEND,
        FILL_REQ,
        FILL_WAIT,
        FILL_WR,
        DONE
    } state_t;

    typedef enum logic {
        OP_WB,
        OP_FILL
    } op_kind_t;

    localparam int unsigned PERF_WIDTH = 32;

endpackage

// File: rtl/sync_perf_ctr.sv
// rtl/sync_perf_ctr.sv - saturating completion counter with synchronous clear
module sync_perf_ctr
    import row_sync_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  inc,
    output logic [PERF_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/row_sync_engine.sv
// rtl/row_sync_engine.sv - row writeback/fill mover between emulation array and backing memory
// Optional SYNC_PERF_EN adds saturating wb_count/fill_count outputs.
module row_sync_engine
    import row_sync_pkg::*;
#(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int DWIDTH    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_req,
    input  logic                          fill_req,
    input  logic [CHWIDTH-1:0]            ch_row,
    input  logic [ADDRWIDTH-1:0]          mem_row,
    output logic                          busy,
    output logic                          sync,
    output logic                          ch_rd_en,
    output logic                          ch_wr_en,
    output logic [CHWIDTH+COLWIDTH-1:0]   ch_addr,
    output logic [DWIDTH-1:0]             ch_wdata,
    input  logic [DWIDTH-1:0]             ch_rdata,
    output logic                          bk_valid,
    input  logic                          bk_ready,
    output logic                          bk_we,
    output logic [ADDRWIDTH+COLWIDTH-1:0] bk_addr,
    output logic [DWIDTH-1:0]             bk_wdata,
    input  logic                          bk_rvalid,
    input  logic [DWIDTH-1:0]             bk_rdata
`ifdef SYNC_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]         wb_count,
    output logic [PERF_WIDTH-1:0]         fill_count
`endif
);

    state_t               state;
    logic [CHWIDTH-1:0]   ch_row_q;
    logic [ADDRWIDTH-1:0] mem_row_q;
    logic [COLWIDTH-1:0]  beat;
    logic [COLWIDTH-1:0]  beat_nxt;
    logic                 last_beat;

    assign beat_nxt  = beat + 1'b1;
    assign last_beat = &beat;

`ifdef SYNC_PERF_EN
    op_kind_t op_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_row_q  <= '0;
            mem_row_q <= '0;
            beat      <= '0;
            busy      <= 1'b0;
            sync      <= 1'b0;
            ch_rd_en  <= 1'b0;
            ch_wr_en  <= 1'b0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
            bk_valid  <= 1'b0;
            bk_we     <= 1'b0;
            bk_addr   <= '0;
            bk_wdata  <= '0;
`ifdef SYNC_PERF_EN
            op_q      <= OP_WB;
`endif
        end else begin
            sync     <= 1'b0;
            ch_rd_en <= 1'b0;
            ch_wr_en <= 1'b0;
            case (state)
                // Writeback has priority; a simultaneous fill stays pending until the next IDLE.
                IDLE: begin
                    if (wb_req) begin
                        ch_row_q  <= ch_row;
                        mem_row_q <= mem_row;
                        beat      <= '0;
                        busy      <= 1'b1;
                        ch_rd_en  <= 1'b1;
                        ch_addr   <= {ch_row, {COLWIDTH{1'b0}}};
                        state     <= WB_RD;
`ifdef SYNC_PERF_EN
                        op_q      <= OP_WB;
`endif
                    end else if (fill_req) begin
                        ch_row_q  <= ch_row;
                        mem_row_q <= mem_row;
                        beat      <= '0;
                        busy      <= 1'b1;
                        bk_valid  <= 1'b1;
                        bk_we     <= 1'b0;
                        bk_addr   <= {mem_row, {COLWIDTH{1'b0}}};
                        state     <= FILL_REQ;
`ifdef SYNC_PERF_EN
                        op_q      <= OP_FILL;
`endif
                    end
                end
                WB_RD: begin
                    state <= WB_CAP;
                end
                WB_CAP: begin
                    bk_wdata <= ch_rdata;
                    bk_valid <= 1'b1;
                    bk_we    <= 1'b1;
                    bk_addr  <= {mem_row_q, beat};
                    state    <= WB_SEND;
                end
                WB_SEND: begin
                    if (bk_ready) begin
                        bk_valid <= 1'b0;
                        bk_we    <= 1'b0;
                        beat     <= beat_nxt;
                        if (last_beat) begin
                            sync  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ch_rd_en <= 1'b1;
                            ch_addr  <= {ch_row_q, beat_nxt};
                            state    <= WB_RD;
                        end
                    end
                end
                FILL_REQ: begin
                    if (bk_ready) begin
                        bk_valid <= 1'b0;
                        state    <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (bk_rvalid) begin
                        ch_wdata <= bk_rdata;
                        ch_wr_en <= 1'b1;
                        ch_addr  <= {ch_row_q, beat};
                        state    <= FILL_WR;
                    end
                end
                FILL_WR: begin
                    beat <= beat_nxt;
                    if (last_beat) begin
                        sync  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bk_valid <= 1'b1;
                        bk_addr  <= {mem_row_q, beat_nxt};
                        state    <= FILL_REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SYNC_PERF_EN
    sync_perf_ctr u_wb_ctr (
        .clk   (clk),
        .clear (rst),
        .inc   (sync && (op_q == OP_WB)),
        .count (wb_count)
    );

    sync_perf_ctr u_fill_ctr (
        .clk   (clk),
        .clear (rst),
        .inc   (sync && (op_q == OP_FILL)),
        .count (fill_count)
    );
`endif

endmodule
